// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared decode-stage types.
//   REG_ADDR_WIDTH   : architectural register address width.
//   inflight_entry_t : one retire-queue slot, {rd, wr}; wr=0 means the
//                      instruction produces no register result worth waiting on.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      wr;
    } inflight_entry_t;

endpackage : riscv_pkg

// File: rtl/idu_issue_ctrl_inflight_queue.sv
// -----------------------------------------------------------------------------
// inflight_queue
//   DEPTH-entry in-order circular buffer of issued-but-not-retired
//   instructions, with a parallel compare against two source addresses.
//
//   clk, reset      : clock, synchronous active-high reset (empties the queue)
//   push/push_entry : append an entry at the tail (caller never pushes when full)
//   pop             : remove the head; ignored when empty
//   q1_adr/q2_adr   : query addresses
//   q1_match/q2_match : some valid entry has wr=1 and rd equal to the query
//   count           : occupancy, 0..DEPTH
//   full / empty    : occupancy flags
// -----------------------------------------------------------------------------
module inflight_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  inflight_entry_t           push_entry,
    input  logic                      pop,
    input  logic [REG_ADDR_WIDTH-1:0] q1_adr,
    input  logic [REG_ADDR_WIDTH-1:0] q2_adr,
    output logic                      q1_match,
    output logic                      q2_match,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    inflight_entry_t    mem [DEPTH];
    logic [DEPTH-1:0]   slot_valid;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // NOTE: the entry payload is not reset; slot_valid alone says which slots
    // are live, so clearing the storage array would only cost reset routing.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap modulo DEPTH for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            slot_valid <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr             <= wr_ptr + PTR_ONE;
                slot_valid[wr_ptr] <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr             <= rd_ptr + PTR_ONE;
                slot_valid[rd_ptr] <= 1'b0;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Every live slot is compared, so duplicate destinations keep the hazard
    // alive until the last of them has retired.
    always_comb begin
        q1_match = 1'b0;
        q2_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && mem[i].wr) begin
                if (mem[i].rd == q1_adr) q1_match = 1'b1;
                if (mem[i].rd == q2_adr) q2_match = 1'b1;
            end
        end
    end

endmodule : inflight_queue

// File: rtl/idu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// idu_issue_ctrl
//   Decode-stage issue/interlock controller. Each cycle decides whether the
//   instruction in the decode register issues to execute or fetch/decode
//   stalls, using an in-order retire queue of in-flight destinations for RAW
//   detection.
//
//   clk, reset                 : clock, synchronous active-high reset
//   dec_valid                  : decode register holds an instruction
//   dec_rs1_adr/dec_rs2_adr    : source addresses
//   dec_rd_adr                 : destination address
//   dec_uses_rs1/2, dec_writes_rd : operand usage flags
//   ex_ready                   : execute can accept this cycle
//   flush                      : redirect, kills the decode instruction
//   ret_valid/ret_we           : oldest in-flight instruction retires
//   issue                      : instruction accepted by execute this cycle
//   stall                      : hold PC/IR/decode register this cycle
//   inflight_cnt               : retire-queue occupancy
//   ret_err                    : sticky, a retire arrived with an empty queue
//   stall_cnt                  : saturating stall-cycle counter
//
//   Build option: define IDU_ISSUE_STATS_EN to build the stall_cnt counter;
//   otherwise stall_cnt is constant zero.
// -----------------------------------------------------------------------------
module idu_issue_ctrl
    import riscv_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int REG_ADDR_WIDTH = riscv_pkg::REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dec_valid,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs1_adr,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs2_adr,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rd_adr,
    input  logic                      dec_uses_rs1,
    input  logic                      dec_uses_rs2,
    input  logic                      dec_writes_rd,
    input  logic                      ex_ready,
    input  logic                      flush,
    input  logic                      ret_valid,
    input  logic                      ret_we,
    output logic                      issue,
    output logic                      stall,
    output logic [$clog2(DEPTH):0]    inflight_cnt,
    output logic                      ret_err,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    inflight_entry_t push_entry;
    logic            q_full;
    logic            q_empty;
    logic            rs1_match;
    logic            rs2_match;
    logic            haz1;
    logic            haz2;

    // x0 never creates a dependency, so it is queued with wr=0.
    assign push_entry.rd = dec_rd_adr;
    assign push_entry.wr = dec_writes_rd && (dec_rd_adr != '0);

    inflight_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (issue),
        .push_entry (push_entry),
        .pop        (ret_valid),
        .q1_adr     (dec_rs1_adr),
        .q2_adr     (dec_rs2_adr),
        .q1_match   (rs1_match),
        .q2_match   (rs2_match),
        .count      (inflight_cnt),
        .full       (q_full),
        .empty      (q_empty)
    );

    // The retiring head is still in the queue this cycle, so it still blocks:
    // there is deliberately no retire-to-issue bypass. Likewise full is the
    // pre-pop occupancy.
    assign haz1  = dec_uses_rs1 && (dec_rs1_adr != '0) && rs1_match;
    assign haz2  = dec_uses_rs2 && (dec_rs2_adr != '0) && rs2_match;
    assign issue = dec_valid && !flush && !haz1 && !haz2 && !q_full && ex_ready;
    assign stall = dec_valid && !flush && !issue;

    // ret_we only tells whether the result was committed; the entry leaves
    // the queue either way.
    logic unused_ret_we;
    assign unused_ret_we = ret_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            ret_err <= 1'b0;
        end else if (ret_valid && q_empty) begin
            ret_err <= 1'b1;
        end
    end

`ifdef IDU_ISSUE_STATS_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule : idu_issue_ctrl

// File: tb/tb_idu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_idu_issue_ctrl
//   Directed bench for idu_issue_ctrl (DEPTH=4). Each vector drives one
//   cycle of inputs and holds the expected combinational issue/stall plus the
//   registered inflight_cnt/ret_err seen before the following clock edge.
// -----------------------------------------------------------------------------
module tb_idu_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int RAW   = 5;
    localparam int CNTW  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            dec_valid;
    logic [RAW-1:0]  dec_rs1_adr, dec_rs2_adr, dec_rd_adr;
    logic            dec_uses_rs1, dec_uses_rs2, dec_writes_rd;
    logic            ex_ready, flush, ret_valid, ret_we;
    logic            issue, stall, ret_err;
    logic [2:0]      inflight_cnt;
    logic [CNTW-1:0] stall_cnt;

    always #5 clk = ~clk;

    idu_issue_ctrl #(
        .DEPTH          (DEPTH),
        .REG_ADDR_WIDTH (RAW),
        .CNT_WIDTH      (CNTW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dec_valid     (dec_valid),
        .dec_rs1_adr   (dec_rs1_adr),
        .dec_rs2_adr   (dec_rs2_adr),
        .dec_rd_adr    (dec_rd_adr),
        .dec_uses_rs1  (dec_uses_rs1),
        .dec_uses_rs2  (dec_uses_rs2),
        .dec_writes_rd (dec_writes_rd),
        .ex_ready      (ex_ready),
        .flush         (flush),
        .ret_valid     (ret_valid),
        .ret_we        (ret_we),
        .issue         (issue),
        .stall         (stall),
        .inflight_cnt  (inflight_cnt),
        .ret_err       (ret_err),
        .stall_cnt     (stall_cnt)
    );

    typedef struct {
        logic           valid;
        logic [RAW-1:0] rs1, rs2, rd;
        logic           u1, u2, wr, exr, flush, rv, rwe;
        logic           e_issue, e_stall;
        logic [2:0]     e_cnt;
        logic           e_err;
    } vec_t;

    int errors      = 0;
    int checks      = 0;
    int exp_stalls  = 0;
    int vec_idx     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        dec_valid = 0; dec_rs1_adr = 0; dec_rs2_adr = 0; dec_rd_adr = 0;
        dec_uses_rs1 = 0; dec_uses_rs2 = 0; dec_writes_rd = 0;
        ex_ready = 1; flush = 0; ret_valid = 0; ret_we = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        dec_valid = v.valid; dec_rs1_adr = v.rs1; dec_rs2_adr = v.rs2; dec_rd_adr = v.rd;
        dec_uses_rs1 = v.u1; dec_uses_rs2 = v.u2; dec_writes_rd = v.wr;
        ex_ready = v.exr; flush = v.flush; ret_valid = v.rv; ret_we = v.rwe;
        #1;
        check($sformatf("issue[%0d]", vec_idx), 32'(issue), 32'(v.e_issue));
        check($sformatf("stall[%0d]", vec_idx), 32'(stall), 32'(v.e_stall));
        check($sformatf("inflight_cnt[%0d]", vec_idx), 32'(inflight_cnt), 32'(v.e_cnt));
        check($sformatf("ret_err[%0d]", vec_idx), 32'(ret_err), 32'(v.e_err));
        if (v.e_stall) exp_stalls++;
        vec_idx++;
    endtask

    //                 valid rs1 rs2 rd  u1 u2 wr exr fl rv rwe  iss stl cnt err
    vec_t tbl [] = '{
        // Independent issue into an empty queue, then ex_ready back-pressure.
        '{1, 3,  4,  0,  1, 1, 0, 1, 0, 0, 0,  1, 0, 0, 0},
        '{1, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 1, 1,  0, 0, 1, 0},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0},
        // RAW on x5: stall, still stalled in the retire cycle, issue after.
        '{1, 0,  0,  5,  0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 0},
        '{1, 5,  0,  0,  1, 0, 0, 1, 0, 0, 0,  0, 1, 1, 0},
        '{1, 5,  0,  0,  1, 0, 0, 1, 0, 1, 1,  0, 1, 1, 0},
        '{1, 5,  0,  6,  1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 1, 0,  0, 0, 1, 0},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0},
        // Write to x0 followed by a reader of x0: never a hazard.
        '{1, 0,  0,  0,  0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 0},
        '{1, 0,  0,  0,  1, 1, 0, 1, 0, 0, 0,  1, 0, 1, 0},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 1, 0,  0, 0, 2, 0},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 1, 0,  0, 0, 1, 0},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0},
        // Fill to DEPTH, 5th blocks, retire while full still blocks.
        '{1, 0,  0, 10,  0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 0},
        '{1, 0,  0, 11,  0, 0, 1, 1, 0, 0, 0,  1, 0, 1, 0},
        '{1, 0,  0, 12,  0, 0, 1, 1, 0, 0, 0,  1, 0, 2, 0},
        '{1, 0,  0, 13,  0, 0, 1, 1, 0, 0, 0,  1, 0, 3, 0},
        '{1, 1,  0,  0,  1, 0, 0, 1, 0, 0, 0,  0, 1, 4, 0},
        '{1, 1,  0,  0,  1, 0, 0, 1, 0, 1, 1,  0, 1, 4, 0},
        '{1, 1,  0,  0,  1, 0, 0, 1, 0, 0, 0,  1, 0, 3, 0},
        // Flush with a live hazard on x12: neither issue nor stall.
        '{1, 12, 0,  0,  1, 0, 0, 1, 1, 0, 0,  0, 0, 4, 0},
        '{1, 12, 0,  0,  1, 0, 0, 1, 1, 1, 0,  0, 0, 4, 0},
        '{1, 12, 0,  0,  1, 0, 0, 1, 0, 0, 0,  0, 1, 3, 0},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 1, 0,  0, 0, 3, 0},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 1, 0,  0, 0, 2, 0},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 1, 0,  0, 0, 1, 0},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0},
        // Retire on an empty queue: sticky error, count stays 0.
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 1, 1,  0, 0, 0, 0},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1},
        '{0, 0,  0,  0,  0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1}
    };

    initial begin
        drive_idle();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        check("reset inflight_cnt", 32'(inflight_cnt), 0);
        check("reset ret_err", 32'(ret_err), 0);
        check("reset stall_cnt", stall_cnt, 0);
        check("reset issue", 32'(issue), 0);

        foreach (tbl[i]) apply_vec(tbl[i]);

        // Two in-flight writers of x7: the rs2 hazard holds until both retire.
        apply_vec('{1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 1});
        apply_vec('{1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0,  1, 0, 1, 1});
        apply_vec('{1, 0, 7, 0, 0, 1, 0, 1, 0, 0, 0,  0, 1, 2, 1});
        apply_vec('{1, 0, 7, 0, 0, 1, 0, 1, 0, 1, 1,  0, 1, 2, 1});
        apply_vec('{1, 0, 7, 0, 0, 1, 0, 1, 0, 1, 1,  0, 1, 1, 1});
        apply_vec('{1, 0, 7, 0, 0, 1, 0, 1, 0, 0, 0,  1, 0, 0, 1});
        apply_vec('{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0,  0, 0, 1, 1});
        apply_vec('{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1});

`ifdef IDU_ISSUE_STATS_EN
        check("stall_cnt total", stall_cnt, 32'(exp_stalls));
`else
        check("stall_cnt tied off", stall_cnt, 0);
`endif

        // Reset in the middle of traffic drops every entry in one cycle.
        apply_vec('{1, 0, 0, 9, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 1});
        apply_vec('{1, 0, 0, 9, 0, 0, 1, 1, 0, 0, 0,  1, 0, 1, 1});
        @(negedge clk);
        drive_idle();
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        check("mid-reset inflight_cnt", 32'(inflight_cnt), 0);
        check("mid-reset ret_err", 32'(ret_err), 0);
        check("mid-reset stall_cnt", stall_cnt, 0);
        // The dropped x9 writers must no longer block a reader of x9.
        apply_vec('{1, 9, 9, 0, 1, 1, 0, 1, 0, 0, 0,  1, 0, 0, 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_idu_issue_ctrl

// File: doc/idu_issue_ctrl.md
Name: idu_issue_ctrl

Overview:
- Issue/interlock controller for the decode stage.
- Decides each cycle whether the instruction held in the decode register may issue to execute, or whether fetch/decode must stall.
- Tracks in-flight destination registers in an in-order retire queue and raises RAW hazards against rs1/rs2.
- Sits beside the decode register: drives its enable (stall) and the execute-stage valid (issue).

Parameters:
- DEPTH, 4, max in-flight (issued, not retired) instructions; power of 2, 2..16.
- REG_ADDR_WIDTH, 5, register address width.
- CNT_WIDTH, 32, width of the stall statistics counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode register holds a valid instruction.
- dec_rs1_adr  in  REG_ADDR_WIDTH  source 1 address.
- dec_rs2_adr  in  REG_ADDR_WIDTH  source 2 address.
- dec_rd_adr  in  REG_ADDR_WIDTH  destination address.
- dec_uses_rs1  in  1  instruction reads rs1.
- dec_uses_rs2  in  1  instruction reads rs2.
- dec_writes_rd  in  1  instruction writes rd.
- ex_ready  in  1  execute stage can accept an instruction this cycle.
- flush  in  1  branch/jump redirect; kills the decode-stage instruction.
- ret_valid  in  1  oldest in-flight instruction retires this cycle (in order).
- ret_we  in  1  retiring instruction actually wrote rd (0 if it was killed downstream).
- issue  out  1  decode instruction is accepted by execute this cycle.
- stall  out  1  hold PC/IR/decode register this cycle.
- inflight_cnt  out  $clog2(DEPTH)+1  occupancy of the retire queue.
- ret_err  out  1  sticky: retire seen with an empty queue.
- stall_cnt  out  CNT_WIDTH  stall statistics counter (optional feature).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state: queue empty; inflight_cnt=0, ret_err=0, stall_cnt=0.
- issue and stall are combinational from the current registered state and inputs, so the decision lands in the same cycle.
- Queue entry: {rd, wr}. On issue, push with wr = dec_writes_rd && (dec_rd_adr != 0).
- Hazard:
  - haz1 = dec_uses_rs1 && dec_rs1_adr != 0 && some valid entry has wr=1 and rd == dec_rs1_adr.
  - haz2 is the same for rs2.
  - full = (inflight_cnt == DEPTH).
- issue = dec_valid && !flush && !haz1 && !haz2 && !full && ex_ready.
- stall = dec_valid && !flush && !issue.
- flush has priority: issue=0 and stall=0, so the decode register is overwritten by the redirect. The queue is not modified; already-issued instructions retire via ret_valid with ret_we=0.
- Retire: on ret_valid with queue non-empty, pop the head. ret_we is informational only; the entry is removed either way.
- Retire with queue empty: ignored, ret_err is set and stays set until reset.
- Same-cycle push and pop: both happen, count unchanged. If full and ret_valid=1, issue is still blocked that cycle, because full is evaluated before the pop.
- A retiring entry still counts in the hazard check during its retire cycle, so a dependent instruction issues the following cycle. There is no bypass from retire to issue.
- Multiple entries with the same rd are legal; the hazard persists until all of them retire.
- Pointer arithmetic is modulo DEPTH; inflight_cnt saturates logically at DEPTH (the push is blocked when full).
- A reset asserted mid-operation discards all entries in one cycle.

Optional Feature:
- Macro: IDU_ISSUE_STATS_EN.
- With the macro defined: stall_cnt increments by 1 on every cycle with stall=1, and saturates at all-ones.
- Without it: stall_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Shared package riscv_pkg holds:
  - REG_ADDR_WIDTH constant.
  - inflight_entry_t packed struct {logic [REG_ADDR_WIDTH-1:0] rd; logic wr;}.
- One sub-module, inflight_queue: DEPTH-entry circular buffer with push/pop, count, and a parallel compare port returning match bits for two query addresses.

Test Plan:
- Reset, then dec_valid=1, rs1=3, rs2=4, uses both, ex_ready=1, queue empty -> issue=1, stall=0, inflight_cnt=1 next cycle.
- Issue "rd=5 wr", then decode uses rs1=5 -> stall=1, issue=0. Pulse ret_valid=1, ret_we=1 -> issue=1 on the cycle after the retire.
- rd=0 write, then an instruction reading x0 -> no stall; the queued entry has wr=0.
- DEPTH=4: issue 4 non-dependent instructions without retire -> 5th stalls with inflight_cnt=4. ret_valid in that cycle -> issue the next cycle, count stays 4.
- flush=1 while a hazard is present -> issue=0, stall=0, queue unchanged. Later ret_valid=1, ret_we=0 pops the killed entry.
- ret_valid=1 on an empty queue -> ret_err=1 and sticky, count stays 0. With IDU_ISSUE_STATS_EN, 7 stall cycles -> stall_cnt=7.
